// File: rtl/logic_unit_pipe_pkg.sv
// logic_unit_pipe_pkg
//   Shared definitions for the logic unit pipeline: the 3-bit operation
//   codes understood by logic_op_core and sampled by logic_unit_pipe.
package logic_unit_pipe_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOR  = 3'd2,
    OP_AND  = 3'd3,
    OP_NAND = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_op_core.sv
// logic_op_core
//   Purely combinational bitwise operation mux, WIDTH bits wide.
//   Ports:
//     op  [2:0]        operation select (see op_e)
//     a   [WIDTH-1:0]  operand A
//     b   [WIDTH-1:0]  operand B (unused by NOT and PASS)
//     y   [WIDTH-1:0]  result
module logic_op_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op_e'(op))
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered bitwise logic unit with a valid/ready handshake, an
//   optional accumulator feeding operand B, registered reductions of the
//   result and a saturating count of accepted beats.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand beat handshake
//     op, acc_mode          operation and B-source select, sampled with beat
//     acc_clr               synchronous accumulator clear
//     a, b                  operands
//     out_valid / out_ready result handshake
//     y                     registered result
//     red_and/or/xor        reductions of y
//     txn_cnt               accepted beat count, saturating at all-ones
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               acc_mode,
  input  logic               acc_clr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               red_and,
  output logic               red_or,
  output logic               red_xor,
  output logic [COUNT_W-1:0] txn_cnt
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign b_eff    = acc_mode ? acc : b;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op (op),
    .a  (a),
    .b  (b_eff),
    .y  (result)
  );

  // Output register: reductions are taken from the result being loaded so
  // they always describe the value presented on y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      red_and   <= 1'b0;
      red_or    <= 1'b0;
      red_xor   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= result;
      red_and   <= &result;
      red_or    <= |result;
      red_xor   <= ^result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear has priority; a coinciding acc_mode beat already used the old
  // value combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept && acc_mode) begin
      acc <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (accept && (txn_cnt != '1)) begin
      txn_cnt <= txn_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [2:0]  op = 3'd0;
  logic        acc_mode = 1'b0;
  logic        acc_clr = 1'b0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [7:0]  y, y2;
  logic        red_and, red_or, red_xor;
  logic        red_and2, red_or2, red_xor2;
  logic [15:0] txn_cnt;
  logic [1:0]  txn_cnt2;

  int checks = 0;
  int failures = 0;

  // consumer mode: 0 random, 1 always ready, 2 never ready
  int rdy_mode = 1;

  typedef struct {
    logic [7:0]  y;
    logic        r_and, r_or, r_xor;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } ent_t;
  ent_t sb[$];

  logic [7:0] m_acc = 8'h00;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .red_and(red_and), .red_or(red_or), .red_xor(red_xor), .txn_cnt(txn_cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
    .red_and(red_and2), .red_or(red_or2), .red_xor(red_xor2), .txn_cnt(txn_cnt2)
  );

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return 8'hFF - x;
      3'd1: return x | z;
      3'd2: return ~(x | z);
      3'd3: return x & z;
      3'd4: return ~(x & z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // consumer
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end
  initial out_ready = 1'b1;

  // monitor: compare head while a result is presented, pop when consumed
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("y", 32'(y), 32'(sb[0].y));
        check("red_and", 32'(red_and), 32'(sb[0].r_and));
        check("red_or", 32'(red_or), 32'(sb[0].r_or));
        check("red_xor", 32'(red_xor), 32'(sb[0].r_xor));
        check("txn_cnt", 32'(txn_cnt), 32'(sb[0].cnt));
        check("txn_cnt_sat", 32'(txn_cnt2), 32'(sb[0].cnt2));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic am, input logic cl, input logic use_exp, input logic [7:0] ex);
    int unsigned n = 0;
    logic rd;
    logic [7:0] r;
    ent_t e;
    op = o; a = av; b = bv; acc_mode = am; acc_clr = cl; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rd = in_ready;
      @(posedge clk);
      if (rd) break;
      if (cl) m_acc = 8'h00;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0; acc_clr = 1'b0;
        return;
      end
    end
    r = ref_op(o, av, am ? m_acc : bv);
    if (am) m_acc = r;
    if (cl) m_acc = 8'h00;
    m_cnt++;
    e.y     = use_exp ? ex : r;
    e.r_and = (e.y == 8'hFF);
    e.r_or  = (e.y != 8'h00);
    e.r_xor = ($countones(e.y) % 2) == 1;
    e.cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    sb.push_back(e);
    #1 in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(posedge clk);
    m_acc = 8'h00;
    #1 acc_clr = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] t1_exp [8] = '{8'h5A, 8'hAF, 8'h50, 8'h05, 8'hFA, 8'hAA, 8'h55, 8'hA5};

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_reds", 32'({red_and, red_or, red_xor}), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all ops
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b1, t1_exp[i]);
    drain();
    check("txn_cnt_after_ops", 32'(txn_cnt), 32'd8);

    // reductions
    send(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h30);
    send(3'd1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    drain();

    // backpressure
    send(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h30);
    rdy_mode = 2;
    fork
      send(3'd5, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h26);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_y_hold", 32'(y), 32'h30);
        end
        rdy_mode = 1;
      end
    join
    drain();

    // accumulate
    clear_acc();
    send(3'd5, 8'h0F, 8'h99, 1'b1, 1'b0, 1'b1, 8'h0F);
    send(3'd5, 8'hF0, 8'h99, 1'b1, 1'b0, 1'b1, 8'hFF);
    send(3'd5, 8'hFF, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00);
    send(3'd5, 8'h11, 8'h99, 1'b1, 1'b1, 1'b1, 8'h11);
    send(3'd5, 8'h22, 8'h99, 1'b1, 1'b0, 1'b1, 8'h22);
    drain();
    check("sat_cnt", 32'(txn_cnt2), 32'd3);

    // randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) clear_acc();
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b0, 8'h00);
    end
    rdy_mode = 1;
    drain();
    check("txn_cnt_total", 32'(txn_cnt), 32'(m_cnt));
    check("sat_cnt_hold", 32'(txn_cnt2), 32'd3);

    // reset mid-operation
    send(3'd5, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    rdy_mode = 2;
    @(negedge clk); #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_reds", 32'({red_and, red_or, red_xor}), 32'd0);
    check("arst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("arst_txn_cnt_sat", 32'(txn_cnt2), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_acc = 8'h00;
    m_cnt = 0;
    rdy_mode = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'd5, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C);
    drain();
    check("post_rst_cnt", 32'(txn_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
